// File: rtl/dmem_copy_engine.sv
// Byte-wise forward copy engine driving a single-port data memory.
// Alternates one READ and one WRITE cycle per byte; supports abort and Len saturation.
module dmem_copy_engine #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Len,
    input  logic [W-1:0] MemRdData,
    output logic [A-1:0] DataAddress,
    output logic         WriteEn,
    output logic [W-1:0] MemWrData,
    output logic         Busy,
    output logic         Done,
    output logic         Aborted,
    output logic [A:0]   Remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [A:0]   MAX_LEN = {1'b1, {A{1'b0}}};
    localparam logic [A:0]   LEN_ONE = (A+1)'(1);
    localparam logic [A-1:0] PTR_ONE = A'(1);

    state_t         state_q, state_d;
    logic [A-1:0]   src_q, src_d;
    logic [A-1:0]   dst_q, dst_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [A:0]     rem_q, rem_d;
    logic           aborted_q, aborted_d;

    // A full memory is the most that can be copied without revisiting addresses.
    function automatic logic [A:0] sat_len(input logic [A:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            buf_q     <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            buf_q     <= buf_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        buf_d       = buf_q;
        rem_d       = rem_q;
        aborted_d   = aborted_q;
        DataAddress = '0;
        WriteEn     = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d     = SrcAddr;
                    dst_d     = DstAddr;
                    rem_d     = sat_len(Len);
                    aborted_d = 1'b0;
                    state_d   = (Len == '0) ? DONE : READ;
                end
            end
            READ: begin
                DataAddress = src_q;
                Busy        = 1'b1;
                if (Abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    buf_d   = MemRdData;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The write driven this cycle always lands, so it is counted even on abort.
                DataAddress = dst_q;
                WriteEn     = 1'b1;
                Busy        = 1'b1;
                src_d       = src_q + PTR_ONE;
                dst_d       = dst_q + PTR_ONE;
                rem_d       = rem_q - LEN_ONE;
                if (Abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (rem_q == LEN_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MemWrData = buf_q;
    assign Aborted   = aborted_q;
    assign Remaining = rem_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a behavioural 256x8 single-port memory.
module tb_dmem_copy_engine;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [7:0] SrcAddr = 8'd0;
    logic [7:0] DstAddr = 8'd0;
    logic [8:0] Len = 9'd0;
    logic [7:0] MemRdData;
    logic [7:0] DataAddress;
    logic       WriteEn;
    logic [7:0] MemWrData;
    logic       Busy;
    logic       Done;
    logic       Aborted;
    logic [8:0] Remaining;

    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;
    int         wr_cnt = 0;
    int         wr_base = 0;
    int         nchecks = 0;
    int         nerr = 0;
    logic [19:0] obs;

    dmem_copy_engine #(.W(8), .A(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
        .MemRdData(MemRdData), .DataAddress(DataAddress), .WriteEn(WriteEn),
        .MemWrData(MemWrData), .Busy(Busy), .Done(Done), .Aborted(Aborted),
        .Remaining(Remaining)
    );

    always #5 Clk = ~Clk;

    assign MemRdData = mem[DataAddress];
    assign obs = {Busy, WriteEn, Done, DataAddress, Remaining};

    always @(posedge Clk) begin
        if (WriteEn) begin
            mem[DataAddress] <= MemWrData;
            wr_cnt <= wr_cnt + 1;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge Clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic go(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        @(negedge Clk);
        SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1;
        wr_base = wr_cnt;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic test_reset();
        Start = 1'b1;
        #1;
        nchecks++;
        if (obs !== 20'd0) begin nerr++; $display("FAIL reset_outputs: got %h expected %h", obs, 20'd0); end
        nchecks++;
        if ({Aborted, MemWrData} !== 9'd0) begin nerr++; $display("FAIL reset_aborted_wrdata: got %h expected 0", {Aborted, MemWrData}); end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        nchecks++;
        if (Busy !== 1'b0) begin nerr++; $display("FAIL reset_hold_start: got Busy=%b expected 0", Busy); end
        Start = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0]  dat [4];
        logic [19:0] exp;
        dat = '{8'd11, 8'd22, 8'd33, 8'd44};
        for (int i = 0; i < 4; i++) load(8'(16 + i), dat[i]);
        go(8'd16, 8'd64, 9'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge Clk);
            if (c == 9) exp = {3'b001, 8'd0, 9'd0};
            else if (c % 2 == 1) exp = {3'b100, 8'(16 + (c - 1) / 2), 9'(4 - (c - 1) / 2)};
            else exp = {3'b110, 8'(64 + c / 2 - 1), 9'(4 - (c - 1) / 2)};
            nchecks++;
            if (obs !== exp) begin nerr++; $display("FAIL basic_cycle%0d: got %h expected %h", c, obs, exp); end
            if (c % 2 == 0 && c < 9) begin
                nchecks++;
                if (MemWrData !== dat[c / 2 - 1]) begin nerr++; $display("FAIL basic_wrdata%0d: got %0d expected %0d", c, MemWrData, dat[c / 2 - 1]); end
            end
            // Inputs disturbed and Start re-pulsed while the copy runs.
            if (c == 1) begin SrcAddr = 8'd0; DstAddr = 8'd0; Len = 9'd1; Start = 1'b1; end
            if (c == 6) Start = 1'b0;
        end
        @(negedge Clk);
        nchecks++;
        if (obs !== 20'd0) begin nerr++; $display("FAIL basic_after_done: got %h expected %h", obs, 20'd0); end
        nchecks++;
        if (wr_cnt - wr_base !== 4) begin nerr++; $display("FAIL basic_write_count: got %0d expected 4", wr_cnt - wr_base); end
        for (int i = 0; i < 4; i++) begin
            nchecks++;
            if (mem[64 + i] !== dat[i]) begin nerr++; $display("FAIL basic_mem%0d: got %0d expected %0d", 64 + i, mem[64 + i], dat[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ra [4];
        logic [7:0] wa [4];
        logic [7:0] ex [4];
        ra = '{8'd254, 8'd255, 8'd0, 8'd1};
        wa = '{8'd0, 8'd1, 8'd2, 8'd3};
        ex = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
        load(8'd254, 8'hA1); load(8'd255, 8'hB2); load(8'd0, 8'hC3); load(8'd1, 8'hD4);
        go(8'd254, 8'd0, 9'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            nchecks++;
            if (c % 2 == 1) begin
                if (DataAddress !== ra[(c - 1) / 2]) begin nerr++; $display("FAIL wrap_rdaddr%0d: got %0d expected %0d", c, DataAddress, ra[(c - 1) / 2]); end
            end else begin
                if (DataAddress !== wa[c / 2 - 1]) begin nerr++; $display("FAIL wrap_wraddr%0d: got %0d expected %0d", c, DataAddress, wa[c / 2 - 1]); end
            end
        end
        @(negedge Clk);
        nchecks++;
        if (Done !== 1'b1) begin nerr++; $display("FAIL wrap_done9: got %b expected 1", Done); end
        for (int i = 0; i < 4; i++) begin
            nchecks++;
            if (mem[i] !== ex[i]) begin nerr++; $display("FAIL wrap_mem%0d: got %h expected %h", i, mem[i], ex[i]); end
        end
    endtask

    task automatic test_len_zero();
        go(8'd5, 8'd6, 9'd0);
        @(negedge Clk);
        nchecks++;
        if ({Done, Busy, WriteEn} !== 3'b100) begin nerr++; $display("FAIL len0_cycle1: got %b expected 100", {Done, Busy, WriteEn}); end
        @(negedge Clk);
        nchecks++;
        if ({Done, wr_cnt - wr_base} !== {1'b0, 32'd0}) begin nerr++; $display("FAIL len0_after: got done=%b writes=%0d expected 0/0", Done, wr_cnt - wr_base); end
    endtask

    task automatic test_saturate();
        int cyc;
        cyc = 0;
        go(8'd0, 8'd0, 9'd300);
        for (int c = 1; c <= 600; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                nchecks++;
                if (Remaining !== 9'd256) begin nerr++; $display("FAIL sat_remaining: got %0d expected 256", Remaining); end
            end
            if (Done) begin cyc = c; break; end
        end
        nchecks++;
        if (cyc !== 513) begin nerr++; $display("FAIL sat_done_cycle: got %0d expected 513", cyc); end
        nchecks++;
        if (wr_cnt - wr_base !== 256) begin nerr++; $display("FAIL sat_write_count: got %0d expected 256", wr_cnt - wr_base); end
    endtask

    task automatic test_abort();
        load(8'd130, 8'h5A);
        go(8'd16, 8'd128, 9'd8);
        repeat (3) @(negedge Clk);
        @(negedge Clk);
        nchecks++;
        if (WriteEn !== 1'b1) begin nerr++; $display("FAIL abort_in_write: got WriteEn=%b expected 1", WriteEn); end
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        nchecks++;
        if ({Done, Aborted, Busy, WriteEn, Remaining} !== {4'b1100, 9'd6}) begin nerr++; $display("FAIL abort_done: got %h expected %h", {Done, Aborted, Busy, WriteEn, Remaining}, {4'b1100, 9'd6}); end
        @(negedge Clk);
        nchecks++;
        if ({Done, Aborted, Busy, Remaining} !== {3'b010, 9'd6}) begin nerr++; $display("FAIL abort_idle: got %h expected %h", {Done, Aborted, Busy, Remaining}, {3'b010, 9'd6}); end
        nchecks++;
        if (wr_cnt - wr_base !== 2) begin nerr++; $display("FAIL abort_write_count: got %0d expected 2", wr_cnt - wr_base); end
        nchecks++;
        if ({mem[128], mem[129], mem[130]} !== {8'd11, 8'd22, 8'h5A}) begin nerr++; $display("FAIL abort_mem: got %h expected %h", {mem[128], mem[129], mem[130]}, {8'd11, 8'd22, 8'h5A}); end

        go(8'd16, 8'd140, 9'd3);
        @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        nchecks++;
        if ({Done, Aborted, Remaining, wr_cnt - wr_base} !== {2'b11, 9'd3, 32'd0}) begin nerr++; $display("FAIL abort_read: got done=%b ab=%b rem=%0d wr=%0d expected 1/1/3/0", Done, Aborted, Remaining, wr_cnt - wr_base); end

        go(8'd16, 8'd150, 9'd1);
        @(negedge Clk);
        @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        nchecks++;
        if ({Done, Aborted, Remaining, wr_cnt - wr_base} !== {2'b11, 9'd0, 32'd1}) begin nerr++; $display("FAIL abort_last_byte: got done=%b ab=%b rem=%0d wr=%0d expected 1/1/0/1", Done, Aborted, Remaining, wr_cnt - wr_base); end

        go(8'd0, 8'd0, 9'd0);
        @(negedge Clk);
        nchecks++;
        if ({Done, Aborted} !== 2'b10) begin nerr++; $display("FAIL abort_cleared_by_start: got %b expected 10", {Done, Aborted}); end
        Abort = 1'b1;
        repeat (2) @(negedge Clk);
        Abort = 1'b0;
        nchecks++;
        if ({Done, Aborted, Busy} !== 3'b000) begin nerr++; $display("FAIL abort_ignored_idle_done: got %b expected 000", {Done, Aborted, Busy}); end
    endtask

    task automatic test_reset_mid();
        go(8'd16, 8'd200, 9'd8);
        repeat (4) @(negedge Clk);
        nchecks++;
        if (WriteEn !== 1'b1) begin nerr++; $display("FAIL rstmid_in_write: got WriteEn=%b expected 1", WriteEn); end
        Reset = 1'b1;
        #1;
        nchecks++;
        if (obs !== 20'd0) begin nerr++; $display("FAIL rstmid_outputs: got %h expected %h", obs, 20'd0); end
        nchecks++;
        if ({Aborted, MemWrData} !== 9'd0) begin nerr++; $display("FAIL rstmid_aborted_wrdata: got %h expected 0", {Aborted, MemWrData}); end
        repeat (2) @(negedge Clk);
        nchecks++;
        if (wr_cnt - wr_base !== 1) begin nerr++; $display("FAIL rstmid_write_count: got %0d expected 1", wr_cnt - wr_base); end
        SrcAddr = 8'd17; DstAddr = 8'd210; Len = 9'd1; Start = 1'b1; Reset = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        nchecks++;
        if (obs !== {3'b100, 8'd17, 9'd1}) begin nerr++; $display("FAIL rstmid_first_start: got %h expected %h", obs, {3'b100, 8'd17, 9'd1}); end
        repeat (2) @(negedge Clk);
        nchecks++;
        if ({Done, mem[210]} !== {1'b1, 8'd22}) begin nerr++; $display("FAIL rstmid_copy_after: got %h expected %h", {Done, mem[210]}, {1'b1, 8'd22}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_saturate();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
